// File: rtl/timer_sched_if.sv
// Request/grant bundle between LED control requesters and the shared timer scheduler.
interface timer_sched_if #(
  parameter int N = 4,
  parameter int W = 6
);
  logic         tick;
  logic [N-1:0] req;
  logic [N*W-1:0] load_val;
  logic [N-1:0] grant;
  logic [N-1:0] done;
  logic [W-1:0] cnt;
  logic         busy;
  logic         led;

  modport master (output tick, req, load_val, input grant, done, cnt, busy, led);
  modport slave  (input tick, req, load_val, output grant, done, cnt, busy, led);
endinterface

// File: rtl/timer_sched.sv
// Round-robin sharing of one down-counter among N requesters; done pulses to the owner on expiry.
// Request-to-done is L ticks plus 3 clocks; dropping req aborts the job silently.
module timer_sched #(
  parameter int N = 4,
  parameter int W = 6
) (
  input logic           clk,
  input logic           rst,
  timer_sched_if.slave  bus
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] own;
  logic [N-1:0]  grant_q;
  logic [N-1:0]  done_q;
  logic [W-1:0]  cnt_q;
  logic          busy_q;
  logic          led_q;

  logic [PW-1:0] pick_idx;
  logic          pick_vld;
  logic [PW-1:0] own_nxt;
  logic          own_req;
  logic [W-1:0]  own_load;

  // First requester at or above the pointer, wrapping modulo N.
  always_comb begin
    pick_idx = '0;
    pick_vld = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!pick_vld && bus.req[(int'(ptr) + k) % N]) begin
        pick_vld = 1'b1;
        pick_idx = PW'((int'(ptr) + k) % N);
      end
    end
  end

  assign own_nxt  = (own == PW'(N - 1)) ? '0 : own + 1'b1;
  assign own_req  = bus.req[own];
  assign own_load = bus.load_val[own*W +: W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ptr     <= '0;
      own     <= '0;
      grant_q <= '0;
      done_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      done_q <= '0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            own              <= pick_idx;
            grant_q          <= '0;
            grant_q[pick_idx] <= 1'b1;
            busy_q           <= 1'b1;
            led_q            <= 1'b1;
            state            <= LOAD;
          end
        end
        LOAD: begin
          if (!own_req) begin
            state   <= IDLE;
            grant_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            led_q   <= 1'b0;
            ptr     <= own_nxt;
          end else begin
            cnt_q <= own_load;
            state <= COUNT;
          end
        end
        COUNT: begin
          if (!own_req) begin
            state   <= IDLE;
            grant_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            led_q   <= 1'b0;
            ptr     <= own_nxt;
          end else if (cnt_q == '0) begin
            done_q[own] <= 1'b1;
            state       <= DONE;
          end else if (bus.tick) begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          grant_q <= '0;
          busy_q  <= 1'b0;
          led_q   <= 1'b0;
          ptr     <= own_nxt;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.cnt   = cnt_q;
  assign bus.busy  = busy_q;
  assign bus.led   = led_q;
endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched: single job, round-robin, zero load, tick gating, abort, mid-count reset.
module tb_timer_sched;
  logic clk;
  logic rst;
  int   nvec;
  int   nerr;

  timer_sched_if #(.N(4), .W(6)) bus ();
  timer_sched #(.N(4), .W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    nvec++;
    if (obs !== want) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, want);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    bus.req = '0;
    bus.tick = 1'b0;
    bus.load_val = '0;
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int edges [4];
    int vals [4];
    int n;
    int early;
    nvec = 0;
    nerr = 0;

    // Reset state
    rst = 1'b0;
    bus.req = '0;
    bus.tick = 1'b0;
    bus.load_val = '0;
    #1;
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_cnt", 32'(bus.cnt), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_led", 32'(bus.led), 0);
    step();
    rst = 1'b1;
    step();

    // Single request, load 5, tick always
    bus.req = 4'b0001;
    bus.load_val = {6'd0, 6'd0, 6'd0, 6'd5};
    bus.tick = 1'b1;
    step();
    chk("single_grant", 32'(bus.grant), 32'h1);
    chk("single_busy", 32'(bus.busy), 1);
    chk("single_led", 32'(bus.led), 1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("single_cnt%0d", i), 32'(bus.cnt), 32'(5 - i));
      chk($sformatf("single_nodone%0d", i), 32'(bus.done), 0);
    end
    step();
    chk("single_done", 32'(bus.done), 32'h1);
    chk("single_grant_in_done", 32'(bus.grant), 32'h1);
    bus.req = '0;
    step();
    chk("single_done_clr", 32'(bus.done), 0);
    chk("single_grant_clr", 32'(bus.grant), 0);
    chk("single_busy_clr", 32'(bus.busy), 0);
    chk("single_led_clr", 32'(bus.led), 0);

    // Round-robin: req 1010 held from reset, load1=2, load3=3
    do_reset();
    bus.req = 4'b1010;
    bus.load_val = {6'd3, 6'd0, 6'd2, 6'd0};
    bus.tick = 1'b1;
    step();
    rst = 1'b1;
    n = 0;
    for (int e = 0; e < 40; e++) begin
      step();
      if (bus.done != '0 && n < 4) begin
        edges[n] = e;
        vals[n] = 32'(bus.done);
        chk($sformatf("rr_grant_at_done%0d", n), 32'(bus.grant), 32'(bus.done));
        n++;
      end
    end
    chk("rr_count", 32'(n), 4);
    chk("rr_edge0", 32'(edges[0]), 4);
    chk("rr_edge1", 32'(edges[1]), 11);
    chk("rr_edge2", 32'(edges[2]), 17);
    chk("rr_edge3", 32'(edges[3]), 24);
    chk("rr_val0", 32'(vals[0]), 32'h2);
    chk("rr_val1", 32'(vals[1]), 32'h8);
    chk("rr_val2", 32'(vals[2]), 32'h2);
    chk("rr_val3", 32'(vals[3]), 32'h8);

    // Zero load
    do_reset();
    rst = 1'b1;
    step();
    bus.req = 4'b0001;
    bus.load_val = '0;
    bus.tick = 1'b1;
    step();
    chk("zero_grant", 32'(bus.grant), 32'h1);
    step();
    chk("zero_cnt", 32'(bus.cnt), 0);
    chk("zero_nodone", 32'(bus.done), 0);
    step();
    chk("zero_done", 32'(bus.done), 32'h1);
    bus.req = '0;
    step();
    step();

    // Tick gating: load 3, tick only on every 4th edge
    bus.req = 4'b0001;
    bus.load_val = {6'd0, 6'd0, 6'd0, 6'd3};
    early = 0;
    for (int k = 0; k <= 12; k++) begin
      bus.tick = (k % 4 == 3);
      step();
      if (k < 12 && bus.done != '0) early++;
      if (k == 5)  chk("gate_hold2", 32'(bus.cnt), 2);
      if (k == 9)  chk("gate_hold1", 32'(bus.cnt), 1);
      if (k == 11) chk("gate_zero", 32'(bus.cnt), 0);
      if (k == 12) chk("gate_done", 32'(bus.done), 32'h1);
    end
    chk("gate_early_done", 32'(early), 0);
    bus.req = '0;
    bus.tick = 1'b1;
    step();
    step();

    // Abort at cnt=2 with requester 1 pending
    do_reset();
    rst = 1'b1;
    step();
    bus.req = 4'b0011;
    bus.load_val = {6'd0, 6'd0, 6'd4, 6'd5};
    bus.tick = 1'b1;
    for (int k = 0; k < 5; k++) step();
    chk("abort_pre_cnt", 32'(bus.cnt), 2);
    bus.req = 4'b0010;
    step();
    chk("abort_grant", 32'(bus.grant), 0);
    chk("abort_cnt", 32'(bus.cnt), 0);
    chk("abort_done", 32'(bus.done), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    step();
    chk("abort_next_grant", 32'(bus.grant), 32'h2);
    early = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (bus.done != '0) early++;
    end
    step();
    chk("abort_next_done", 32'(bus.done), 32'h2);
    chk("abort_no_done_early", 32'(early), 0);
    bus.req = '0;
    step();

    // Asynchronous reset at cnt=3, then full re-run
    do_reset();
    rst = 1'b1;
    step();
    bus.req = 4'b0001;
    bus.load_val = {6'd0, 6'd0, 6'd0, 6'd6};
    bus.tick = 1'b1;
    for (int k = 0; k < 5; k++) step();
    chk("mid_pre_cnt", 32'(bus.cnt), 3);
    #2 rst = 1'b0;
    #1;
    chk("mid_grant", 32'(bus.grant), 0);
    chk("mid_cnt", 32'(bus.cnt), 0);
    chk("mid_busy", 32'(bus.busy), 0);
    chk("mid_led", 32'(bus.led), 0);
    chk("mid_done", 32'(bus.done), 0);
    #2 rst = 1'b1;
    step();
    chk("mid_regrant", 32'(bus.grant), 32'h1);
    step();
    chk("mid_reload", 32'(bus.cnt), 6);
    early = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (bus.done != '0) early++;
    end
    step();
    chk("mid_final_done", 32'(bus.done), 32'h1);
    chk("mid_no_done_early", 32'(early), 0);
    bus.req = '0;
    step();
    chk("mid_idle", 32'(bus.grant), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/timer_sched.md
# timer_sched

Round-robin scheduler that shares a single down-counting timer among `N` requesters. Each requester raises a request with its own load value. The block grants one requester at a time, loads the shared counter, and counts down on the `tick` enable. When the count expires it returns a one-cycle `done` pulse to the owner. It sits between the panel/LED control logic and the timer datapath, so each LED channel does not need its own counter.

## Interface
Parameters:
- `N`, default 4: number of requesters (2..8).
- `W`, default 6: counter and load-value width.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `tick`, in, 1: count enable (prescaled strobe); the counter decrements only on cycles with `tick`=1.
- `req`, in, N: per-requester request level; must be held until `done` is seen.
- `load_val`, in, N*W: packed load values; requester i uses bits [i*W +: W], sampled in the LOAD state.
- `grant`, out, N: one-hot owner of the timer; all zero when idle.
- `done`, out, N: one-cycle pulse on the owner's bit when its count expires.
- `cnt`, out, W: current counter value.
- `busy`, out, 1: high in the LOAD, COUNT and DONE states.
- `led`, out, 1: equals `busy`, registered; drives the timer-active indicator.

## Operation
- All outputs are registered. Reset drives state=IDLE, `grant`=0, `done`=0, `cnt`=0, `busy`=0, `led`=0, RR pointer=0.
- **IDLE**
  - If `req`≠0: choose the first set bit scanning from the pointer upward, wrapping modulo N.
  - Set `grant` to that bit and go to LOAD.
- **LOAD**
  - If the owner's `req`=0: abort.
  - Otherwise `cnt` ← owner's load value and go to COUNT.
- **COUNT** (priority order)
  1. Owner's `req`=0: abort.
  2. `cnt`=0: go to DONE.
  3. `tick`=1: `cnt` ← `cnt`−1.
- **DONE**
  - `done[owner]`=1 for exactly this cycle.
  - `grant` ← 0, pointer ← owner+1 (mod N), go to IDLE.
- **Abort**
  - Next state IDLE, `grant` ← 0, `cnt` ← 0, pointer ← owner+1.
  - No `done` pulse.
- **Counter rules**
  - Load value 0 passes through COUNT for one cycle, then DONE; no tick is consumed.
  - The counter never decrements below 0; no wrap-around.
- **Arbitration**
  - Requests arriving while busy wait; they are never dropped while `req` stays high.
  - A requester whose `req` stays high after its `done` is re-served only after every other pending requester.
- **Other cases**
  - `tick` during LOAD or DONE is ignored.
  - Changes to `load_val` after LOAD have no effect.

## Timing
- Request edge E0: `req` is first sampled high in IDLE at E0.
  - E0: `grant`, `busy` high.
  - E1: `cnt`=L.
- With `tick` held at 1:
  - `cnt` reaches 0 at E1+L.
  - State is DONE after E2+L; `done` is high during the cycle after E2+L.
  - `grant`=0 and IDLE after E3+L.
- Request to `done` latency is L+3 clocks (tick=1); with gated tick, L ticks plus 3 clocks.
- Back-to-back service: the next requester is granted at the edge after returning to IDLE, so there is one IDLE cycle between jobs.
- Abort takes effect at the first edge that samples the owner's `req` low.
- Asynchronous reset mid-operation clears everything immediately, with no `done` pulse; operation resumes from IDLE on the first edge after `rst` deasserts.

## Test plan
- **Single request:** N=4, `req`=0001, load 5, `tick`=1. Expect `grant`=0001, `cnt` sequence 5,4,3,2,1,0, `done`=0001 for exactly one cycle 8 clocks after request, then `grant`=0.
- **Round-robin:** `req`=1010 held from reset, loads 2 and 3. Expect served order 1, 3, 1, 3. Each `done` goes to the correct bit, and there is one IDLE cycle between jobs.
- **Zero load and tick gating:**
  - Load 0: expect `done` 3 clocks after request.
  - Load 3 with `tick` every 4th cycle: expect `cnt` to hold between ticks and `done` after 3 ticks plus 3 clocks.
- **Abort:** owner drops `req` at `cnt`=2. Expect IDLE next edge, `grant`=0, `cnt`=0, no `done`, and a pending requester granted next.
- **Reset mid-count:** pulse `rst` low at `cnt`=3. Expect all outputs 0 immediately and no `done`. After release, a still-high `req` is re-granted and completes its full count.
